mem_arb: RTL and testbench

- Two-port request arbiter directly upstream of the memory controller (memc).
- Accepts single-beat read/write requests from the 6502 core port (cpu_*) and the debug/loader port (dbg_*).
- Serialises them onto memc's enable/addr/data interface, honouring memc_busy.
- Returns read data and a one-cycle ack to the winning requester.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_if.sv | 40 ++++
 rtl/mem_arb_rr.sv | 8 +
 rtl/mem_arb.sv | 135 +++++++++++++
 tb/tb_mem_arb.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and port identifiers for the memc request arbiter.
package mem_arb_pkg;
    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_ISSUE = 4'b0010;
    localparam logic [3:0] S_WAIT  = 4'b0100;
    localparam logic [3:0] S_DONE  = 4'b1000;
    typedef enum logic [3:0] {
        IDLE  = S_IDLE,
        ISSUE = S_ISSUE,
        WAIT  = S_WAIT,
        DONE  = S_DONE
    } state_t;
    localparam logic CPU = 1'b0;
    localparam logic DBG = 1'b1;
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: requester (cpu/dbg) and memc signal bundle; slave is the arbiter side.
interface mem_arb_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wr_data;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rd_data;
    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wr_data;
    logic                  dbg_ack;
    logic [DATA_WIDTH-1:0] dbg_rd_data;
    logic                  memc_busy;
    logic                  memc_rd_enable;
    logic                  memc_wr_enable;
    logic [ADDR_WIDTH-1:0] memc_addr;
    logic [DATA_WIDTH-1:0] memc_wr_data;
    logic [DATA_WIDTH-1:0] memc_rd_data;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wr_data,
        output cpu_ack, cpu_rd_data,
        input  dbg_req, dbg_we, dbg_addr, dbg_wr_data,
        output dbg_ack, dbg_rd_data,
        input  memc_busy, memc_rd_data,
        output memc_rd_enable, memc_wr_enable, memc_addr, memc_wr_data
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wr_data,
        input  cpu_ack, cpu_rd_data,
        output dbg_req, dbg_we, dbg_addr, dbg_wr_data,
        input  dbg_ack, dbg_rd_data,
        output memc_busy, memc_rd_data,
        input  memc_rd_enable, memc_wr_enable, memc_addr, memc_wr_data
    );
endinterface

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 2-way round-robin picker; on a tie the port that did not win last time goes.
module mem_arb_rr (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);
    assign grant = (req[0] && req[1]) ? ~last_grant : req[1];
endmodule

// File: rtl/mem_arb.sv
// mem_arb: serialises single-beat cpu/dbg requests onto memc strobes and returns data + ack.
// Every output is a register so memc and the requesters see glitch-free strobes.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 16,
    parameter int STROBE_CYCLES = 2,
    parameter int RD_LATENCY    = 3
) (
    input  logic       arb_clk,
    input  logic       arb_reset,
    mem_arb_if.slave   bus
);
    localparam int MAX_CYC = (STROBE_CYCLES > RD_LATENCY) ? STROBE_CYCLES : RD_LATENCY;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LD     = CW'(RD_LATENCY - 1);

    if (STROBE_CYCLES < 1 || RD_LATENCY < 1) begin : g_param_err
        $error("mem_arb: STROBE_CYCLES and RD_LATENCY must both be >= 1");
    end

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  grant, grant_n, last_grant, last_n, pick;
    logic                  we, we_n, rd_en, rd_en_n, wr_en, wr_en_n;
    logic                  cpu_ack, cpu_ack_n, dbg_ack, dbg_ack_n;
    logic [ADDR_WIDTH-1:0] addr, addr_n;
    logic [DATA_WIDTH-1:0] wdata, wdata_n, cpu_rd, cpu_rd_n, dbg_rd, dbg_rd_n;

    mem_arb_rr u_rr (
        .req        ({bus.dbg_req, bus.cpu_req}),
        .last_grant (last_grant),
        .grant      (pick)
    );

    always_ff @(posedge arb_clk or posedge arb_reset) begin
        if (arb_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            grant      <= CPU;
            last_grant <= DBG;
            we         <= 1'b0;
            rd_en      <= 1'b0;
            wr_en      <= 1'b0;
            cpu_ack    <= 1'b0;
            dbg_ack    <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            cpu_rd     <= '0;
            dbg_rd     <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            grant      <= grant_n;
            last_grant <= last_n;
            we         <= we_n;
            rd_en      <= rd_en_n;
            wr_en      <= wr_en_n;
            cpu_ack    <= cpu_ack_n;
            dbg_ack    <= dbg_ack_n;
            addr       <= addr_n;
            wdata      <= wdata_n;
            cpu_rd     <= cpu_rd_n;
            dbg_rd     <= dbg_rd_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        grant_n   = grant;
        last_n    = last_grant;
        we_n      = we;
        rd_en_n   = rd_en;
        wr_en_n   = wr_en;
        cpu_ack_n = 1'b0;
        dbg_ack_n = 1'b0;
        addr_n    = addr;
        wdata_n   = wdata;
        cpu_rd_n  = cpu_rd;
        dbg_rd_n  = dbg_rd;
        case (state)
            IDLE: if (!bus.memc_busy && (bus.cpu_req || bus.dbg_req)) begin
                grant_n = pick;
                we_n    = pick ? bus.dbg_we : bus.cpu_we;
                addr_n  = pick ? bus.dbg_addr : bus.cpu_addr;
                wdata_n = pick ? bus.dbg_wr_data : bus.cpu_wr_data;
                rd_en_n = !we_n;
                wr_en_n = we_n;
                cnt_n   = STROBE_LD;
                state_n = ISSUE;
            end
            ISSUE: if (cnt == '0) begin
                rd_en_n = 1'b0;
                wr_en_n = 1'b0;
                // writes finish with the strobe; reads wait out the memc latency
                if (we) begin
                    cpu_ack_n = (grant == CPU);
                    dbg_ack_n = (grant == DBG);
                    state_n   = DONE;
                end else begin
                    cnt_n   = RD_LD;
                    state_n = WAIT;
                end
            end else begin
                cnt_n = cnt - 1'b1;
            end
            WAIT: if (cnt == '0) begin
                cpu_rd_n  = (grant == CPU) ? bus.memc_rd_data : cpu_rd;
                dbg_rd_n  = (grant == DBG) ? bus.memc_rd_data : dbg_rd;
                cpu_ack_n = (grant == CPU);
                dbg_ack_n = (grant == DBG);
                state_n   = DONE;
            end else begin
                cnt_n = cnt - 1'b1;
            end
            DONE: begin
                last_n  = grant;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.cpu_ack        = cpu_ack;
    assign bus.dbg_ack        = dbg_ack;
    assign bus.cpu_rd_data    = cpu_rd;
    assign bus.dbg_rd_data    = dbg_rd;
    assign bus.memc_rd_enable = rd_en;
    assign bus.memc_wr_enable = wr_en;
    assign bus.memc_addr      = addr;
    assign bus.memc_wr_data   = wdata;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed cycle-accurate bench for mem_arb with a read-completion scoreboard.
module tb_mem_arb;
    typedef struct packed {
        logic       port;
        logic [7:0] rd;
    } exp_t;

    logic arb_clk;
    logic arb_reset;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    mem_arb_if bus ();

    mem_arb dut (
        .arb_clk   (arb_clk),
        .arb_reset (arb_reset),
        .bus       (bus)
    );

    initial arb_clk = 1'b0;
    always #5 arb_clk = ~arb_clk;

    task automatic cyc();
        @(posedge arb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag, output int lat);
        exp_t e;
        lat = 0;
        cyc();
        while (!(bus.cpu_ack || bus.dbg_ack) && lat < 30) begin
            cyc();
            lat++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk({tag, "_ack_count"}, 32'(bus.cpu_ack) + 32'(bus.dbg_ack), 32'd1);
        chk({tag, "_ack_port"}, {31'd0, bus.dbg_ack}, {31'd0, e.port});
        chk({tag, "_rd_data"}, {24'd0, e.port ? bus.dbg_rd_data : bus.cpu_rd_data}, {24'd0, e.rd});
    endtask

    initial begin
        int lat;
        int bad;
        arb_reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wr_data = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wr_data = '0;
        bus.memc_busy = 1'b0; bus.memc_rd_data = '0;
        repeat (3) cyc();
        chk("rst_rd_en", {31'd0, bus.memc_rd_enable}, 0);
        chk("rst_acks", {30'd0, bus.cpu_ack, bus.dbg_ack}, 0);
        chk("rst_addr", {16'd0, bus.memc_addr}, 0);
        arb_reset = 1'b0;
        cyc();

        // reset asserted mid-cycle while a read strobe is out
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h1111;
        cyc();
        chk("pre_rst_rd_en", {31'd0, bus.memc_rd_enable}, 1);
        #3 arb_reset = 1'b1;
        bus.cpu_req = 1'b0;
        #1;
        chk("async_rst_rd_en", {31'd0, bus.memc_rd_enable}, 0);
        chk("async_rst_addr", {16'd0, bus.memc_addr}, 0);
        chk("async_rst_acks", {30'd0, bus.cpu_ack, bus.dbg_ack}, 0);
        cyc();
        arb_reset = 1'b0;
        cyc();

        // contention straight after reset: CPU must win first, then alternate
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0100;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 16'h0300;
        bus.memc_rd_data = 8'h10;
        exp_q.push_back('{1'b0, 8'h10});
        exp_q.push_back('{1'b1, 8'h11});
        exp_q.push_back('{1'b0, 8'h12});
        exp_q.push_back('{1'b1, 8'h13});
        for (int i = 0; i < 4; i++) begin
            wait_ack("contend", lat);
            bus.memc_rd_data = 8'(8'h11 + i);
        end
        bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
        cyc();

        // CPU read with data valid only in cycle 5
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234;
        bus.memc_rd_data = 8'hEE;
        exp_q.push_back('{1'b0, 8'hA5});
        cyc();
        chk("rd_c1_en", {30'd0, bus.memc_rd_enable, bus.memc_wr_enable}, 32'b10);
        chk("rd_c1_addr", {16'd0, bus.memc_addr}, 32'h1234);
        cyc();
        chk("rd_c2_en", {31'd0, bus.memc_rd_enable}, 1);
        cyc();
        chk("rd_c3_en", {31'd0, bus.memc_rd_enable}, 0);
        cyc();
        chk("rd_c4_ack", {31'd0, bus.cpu_ack}, 0);
        cyc();
        bus.memc_rd_data = 8'hA5;
        wait_ack("cpu_rd", lat);
        chk("cpu_rd_latency", 32'(lat), 0);
        chk("cpu_rd_dbg_iso", {24'd0, bus.dbg_rd_data}, 32'h13);
        bus.memc_rd_data = 8'hEE;
        bus.cpu_req = 1'b0;
        cyc();
        chk("cpu_ack_pulse", {31'd0, bus.cpu_ack}, 0);

        // DBG write
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 16'h0200; bus.dbg_wr_data = 8'h5A;
        cyc();
        chk("wr_c1_en", {30'd0, bus.memc_rd_enable, bus.memc_wr_enable}, 32'b01);
        chk("wr_c1_addr", {16'd0, bus.memc_addr}, 32'h0200);
        chk("wr_c1_data", {24'd0, bus.memc_wr_data}, 32'h5A);
        cyc();
        chk("wr_c2_en", {30'd0, bus.memc_rd_enable, bus.memc_wr_enable}, 32'b01);
        cyc();
        chk("wr_c3_ack", {30'd0, bus.dbg_ack, bus.cpu_ack}, 32'b10);
        chk("wr_c3_en", {30'd0, bus.memc_rd_enable, bus.memc_wr_enable}, 0);
        bus.dbg_req = 1'b0;
        cyc();
        chk("wr_ack_pulse", {31'd0, bus.dbg_ack}, 0);
        chk("wr_data_hold", {24'd0, bus.memc_wr_data}, 32'h5A);

        // busy holds the request off; busy rising during WAIT is ignored
        bus.memc_busy = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0042;
        bus.memc_rd_data = 8'h42;
        exp_q.push_back('{1'b0, 8'h42});
        bad = 0;
        repeat (20) begin
            cyc();
            if (bus.memc_rd_enable || bus.memc_wr_enable || bus.cpu_ack) bad++;
        end
        chk("busy_hold", 32'(bad), 0);
        bus.memc_busy = 1'b0;
        cyc();
        chk("busy_release_en", {31'd0, bus.memc_rd_enable}, 1);
        cyc();
        cyc();
        bus.memc_busy = 1'b1;
        wait_ack("busy_wait", lat);
        bus.cpu_req = 1'b0;
        bus.memc_busy = 1'b0;
        cyc();

        // reset pulsed during WAIT aborts without an ack
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0ABC; bus.memc_rd_data = 8'h99;
        repeat (3) cyc();
        #2 arb_reset = 1'b1;
        bus.cpu_req = 1'b0;
        #1;
        chk("abort_en", {30'd0, bus.memc_rd_enable, bus.memc_wr_enable}, 0);
        chk("abort_ack", {30'd0, bus.cpu_ack, bus.dbg_ack}, 0);
        cyc();
        arb_reset = 1'b0;
        bad = 0;
        repeat (10) begin
            cyc();
            if (bus.cpu_ack || bus.dbg_ack || bus.memc_rd_enable || bus.memc_wr_enable) bad++;
        end
        chk("abort_quiet", 32'(bad), 0);
        bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0DEF; bus.memc_rd_data = 8'h66;
        exp_q.push_back('{1'b0, 8'h66});
        wait_ack("post_abort", lat);
        chk("post_abort_latency", 32'(lat), 5);
        chk("post_abort_dbg_iso", {24'd0, bus.dbg_rd_data}, 0);
        bus.cpu_req = 1'b0;
        cyc();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
